// File: rtl/axi_rd_burst_issuer.sv
// ---------------------------------------------------------------------------
// axi_rd_burst_issuer
//
// Purpose:
//    Read-side AXI4 burst engine for the VDMA read path. It takes full or
//    tail burst requests from the read FIFO status controller, issues one
//    INCR burst per request on the AR channel, streams the returned R beats
//    into the read FIFO and reports acceptance (resp) and completion (done)
//    back to the controller. It also owns the per-frame address pointer and
//    the count of beats still to be read in the frame. That count is
//    reported back to the controller as tail_status/tail_len.
//
//    Every beat is a full-width beat (AxSIZE = log2(DATA_WIDTH/8), 3'b101
//    for 256-bit data) of an INCR burst. Both are fixed, so there are no
//    size or burst-type ports. The pointer therefore advances by
//    len * (DATA_WIDTH/8) bytes per burst.
//
// Ports:
//    clock, rst_n              system clock, asynchronous active-low reset
//    base_addr, fsync          frame base byte address, frame start pulse
//    burst_req, tail_req       full / tail burst request (level, held until resp)
//    req_len                   beats requested, valid with the request
//    resp, done                1-cycle pulses: request taken / burst received
//    tail_status, tail_len     remaining beats < BURST_LEN, remaining beats
//    araddr, arlen, arvalid    AXI AR channel outputs
//    arready                   AXI AR channel ready
//    rdata, rvalid, rlast      AXI R channel inputs
//    rready                    AXI R channel ready
//    fifo_wr_en, fifo_wr_data  read FIFO write port
// ---------------------------------------------------------------------------
module axi_rd_burst_issuer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 256,
   parameter int LSIZE       = 9,
   parameter int BURST_LEN   = 100,
   parameter int FRAME_BEATS = 250
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  fsync,
   input  logic                  burst_req,
   input  logic                  tail_req,
   input  logic [LSIZE-1:0]      req_len,
   output logic                  resp,
   output logic                  done,
   output logic                  tail_status,
   output logic [LSIZE-1:0]      tail_len,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  rvalid,
   input  logic                  rlast,
   output logic                  rready,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_wr_data
);

   // Bytes moved per beat, and the width of the per-frame beat counter.
   // FRAME_BEATS is always below 2^20.
   localparam int BPB = DATA_WIDTH / 8;
   localparam int RW  = 20;

   typedef enum logic [1:0] {
      IDLE,
      AR,
      RDATA,
      ZERO
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addrPtr_q;
   logic [RW-1:0]         remain_q;
   logic [LSIZE-1:0]      len_q;
   logic                  fsyncPend_q;
   logic [ADDR_WIDTH-1:0] baseLatch_q;
   logic                  resp_q;
   logic                  done_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [7:0]            arlen_q;
   logic                  arvalid_q;
   logic                  rready_q;
   logic                  fifoWrEn_q;
   logic [DATA_WIDTH-1:0] fifoWrData_q;
   logic                  tailStatus_q;
   logic [LSIZE-1:0]      tailLen_q;

   logic [ADDR_WIDTH-1:0] addrPtr_d;
   logic [RW-1:0]         remain_d;
   logic                  rBeat;

   // Pointer and remaining-count values that are committed when the AR
   // handshake completes. The pointer wraps modulo 2^ADDR_WIDTH. The
   // remaining count saturates at zero, so an oversized tail request
   // cannot wrap it around to a large value.
   always_comb begin
      addrPtr_d = addrPtr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(BPB);
      if (remain_q < RW'(len_q)) begin
         remain_d = '0;
      end else begin
         remain_d = remain_q - RW'(len_q);
      end
      rBeat = rvalid & rready_q;
   end

   // The main controller: state, frame bookkeeping and every output is
   // registered in this one block.
   //
   // resp/done are single-cycle pulses, so they default to 0 each cycle.
   // The FIFO write strobe simply follows accepted R beats one cycle later.
   //
   // An fsync seen outside IDLE is only remembered (with the base address it
   // arrived with), so the in-flight burst always finishes on AXI. The
   // pointer reset is applied on the first IDLE cycle after the burst.
   //
   // In IDLE a frame restart takes priority over a request. The request
   // stays held by the controller and is taken on the following cycle.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addrPtr_q    <= '0;
         remain_q     <= RW'(FRAME_BEATS);
         len_q        <= '0;
         fsyncPend_q  <= 1'b0;
         baseLatch_q  <= '0;
         resp_q       <= 1'b0;
         done_q       <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         fifoWrEn_q   <= 1'b0;
         fifoWrData_q <= '0;
         tailStatus_q <= 1'b0;
         tailLen_q    <= '0;
      end else begin
         resp_q       <= 1'b0;
         done_q       <= 1'b0;
         fifoWrEn_q   <= rBeat;
         if (rBeat) begin
            fifoWrData_q <= rdata;
         end
         tailStatus_q <= (remain_q < RW'(BURST_LEN));
         tailLen_q    <= remain_q[LSIZE-1:0];

         if (fsync && (state_q != IDLE)) begin
            fsyncPend_q <= 1'b1;
            baseLatch_q <= base_addr;
         end

         case (state_q)
            IDLE: begin
               if (fsyncPend_q || fsync) begin
                  addrPtr_q   <= fsync ? base_addr : baseLatch_q;
                  remain_q    <= RW'(FRAME_BEATS);
                  fsyncPend_q <= 1'b0;
               end else if (burst_req || tail_req) begin
                  len_q <= req_len;
                  if (req_len == '0) begin
                     resp_q  <= 1'b1;
                     state_q <= ZERO;
                  end else begin
                     araddr_q  <= addrPtr_q;
                     arlen_q   <= 8'(req_len - LSIZE'(1));
                     arvalid_q <= 1'b1;
                     state_q   <= AR;
                  end
               end
            end

            AR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  resp_q    <= 1'b1;
                  addrPtr_q <= addrPtr_d;
                  remain_q  <= remain_d;
                  rready_q  <= 1'b1;
                  state_q   <= RDATA;
               end
            end

            RDATA: begin
               if (rBeat && rlast) begin
                  rready_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
            end

            ZERO: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign resp         = resp_q;
   assign done         = done_q;
   assign araddr       = araddr_q;
   assign arlen        = arlen_q;
   assign arvalid      = arvalid_q;
   assign rready       = rready_q;
   assign fifo_wr_en   = fifoWrEn_q;
   assign fifo_wr_data = fifoWrData_q;
   assign tail_status  = tailStatus_q;
   assign tail_len     = tailLen_q;

endmodule

// File: tb/tb_axi_rd_burst_issuer.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_burst_issuer
//
// Directed bench for axi_rd_burst_issuer with the default parameters
// (32-bit address, 256-bit data, BURST_LEN=100, FRAME_BEATS=250).
//
// Inputs are driven and outputs are sampled on the falling clock edge. A
// value registered on a rising edge is visible at the following falling
// edge.
// ---------------------------------------------------------------------------
module tb_axi_rd_burst_issuer;

   localparam int AW = 32;
   localparam int DW = 256;
   localparam int LS = 9;

   logic          clock = 1'b0;
   logic          rst_n;
   logic [AW-1:0] base_addr;
   logic          fsync;
   logic          burst_req;
   logic          tail_req;
   logic [LS-1:0] req_len;
   logic          resp;
   logic          done;
   logic          tail_status;
   logic [LS-1:0] tail_len;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          rlast;
   logic          rready;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   axi_rd_burst_issuer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSIZE(LS),
      .BURST_LEN(100), .FRAME_BEATS(250)
   ) dut (
      .clock(clock), .rst_n(rst_n), .base_addr(base_addr), .fsync(fsync),
      .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
      .resp(resp), .done(done), .tail_status(tail_status), .tail_len(tail_len),
      .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data)
   );

   // Emits a one-cycle fsync carrying a new base address.
   task automatic pulseFsync(input logic [AW-1:0] addr);
      base_addr = addr;
      fsync     = 1'b1;
      @(negedge clock);
      fsync     = 1'b0;
   endtask

   // Raises a request and plays the AR slave, holding off arready for
   // arDelay cycles. It records what the DUT showed so that the caller can
   // compare it.
   task automatic doAddrPhase(input bit isTail, input int len, input int arDelay,
                              output logic [AW-1:0] firstAddr, output logic [7:0] firstLen,
                              output logic firstValid, output int unstable,
                              output logic respAccept, output logic arvalidAfter,
                              output logic rreadyAfter, output logic respAfter);
      burst_req = !isTail;
      tail_req  = isTail;
      req_len   = LS'(len);
      @(negedge clock);
      firstAddr  = araddr;
      firstLen   = arlen;
      firstValid = arvalid;
      unstable   = 0;
      for (int d = 0; d < arDelay; d++) begin
         @(negedge clock);
         if (araddr !== firstAddr || arlen !== firstLen || arvalid !== 1'b1 || resp !== 1'b0)
            unstable++;
      end
      arready = 1'b1;
      @(negedge clock);
      respAccept   = resp;
      arvalidAfter = arvalid;
      rreadyAfter  = rready;
      arready   = 1'b0;
      burst_req = 1'b0;
      tail_req  = 1'b0;
      @(negedge clock);
      respAfter = resp;
   endtask

   // Plays the R slave for nBeats beats. If toggle is set, rvalid is
   // offered only on every other cycle. A one-cycle fsync is raised with
   // beat fsyncBeat. The task counts FIFO writes, checks each written word
   // against the beat pattern in order, and measures the distance from the
   // rlast beat to done. The loop is bounded in cycles.
   task automatic runReadData(input int nBeats, input bit toggle, input int fsyncBeat,
                              input int seed, output int wrCount, output int badData,
                              output int doneCount, output int doneLatency,
                              output logic rreadyEnd);
      int beatIdx     = 0;
      int cyc         = 0;
      int lastBeatCyc = -100;
      int doneAt      = -1;
      bit valid;
      wrCount   = 0;
      badData   = 0;
      doneCount = 0;
      while (cyc < 2000 && !(beatIdx == nBeats && cyc >= lastBeatCyc + 4)) begin
         if (fifo_wr_en === 1'b1) begin
            if (fifo_wr_data !== {DW/32{32'(seed + wrCount)}}) badData++;
            wrCount++;
         end
         if (done === 1'b1) begin
            doneCount++;
            doneAt = cyc;
         end
         valid  = (beatIdx < nBeats) && (!toggle || (cyc % 2 == 0));
         rvalid = valid;
         rdata  = {DW/32{32'(seed + beatIdx)}};
         rlast  = valid && (beatIdx == nBeats - 1);
         fsync  = valid && (beatIdx == fsyncBeat);
         if (valid && rready === 1'b1) begin
            if (beatIdx == nBeats - 1) lastBeatCyc = cyc;
            beatIdx++;
         end
         @(negedge clock);
         cyc++;
      end
      rvalid      = 1'b0;
      rlast       = 1'b0;
      fsync       = 1'b0;
      doneLatency = doneAt - lastBeatCyc;
      rreadyEnd   = rready;
   endtask

   // Reset values while reset is held, then the frame count once released.
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if ({resp, done, arvalid, rready, fifo_wr_en} !== 5'b0) begin errors++;
         $display("[TB] FAIL reset ctrl: got %b expected 00000", {resp, done, arvalid, rready, fifo_wr_en}); end
      checks++; if (araddr !== '0 || arlen !== '0) begin errors++;
         $display("[TB] FAIL reset ar: got %h/%h expected 0/0", araddr, arlen); end
      checks++; if ({tail_status, tail_len} !== '0) begin errors++;
         $display("[TB] FAIL reset tail: got %b/%0d expected 0/0", tail_status, tail_len); end
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (tail_status !== 1'b0 || tail_len !== 9'd250) begin errors++;
         $display("[TB] FAIL reset remain: got %b/%0d expected 0/250", tail_status, tail_len); end
   endtask

   // Two full bursts and one tail burst through a 250-beat frame.
   task automatic test_frame_sequence;
      logic [AW-1:0] fa; logic [7:0] fl; logic fv, ra, aa, rr, rf, re;
      int us, wc, bd, dc, dl;
      logic [AW-1:0] expAddr [3];
      int            lens    [3];
      logic          expTs   [3];
      int            expTl   [3];
      expAddr = '{32'h1000_0000, 32'h1000_0C80, 32'h1000_1900};
      lens    = '{100, 100, 50};
      expTs   = '{1'b0, 1'b1, 1'b1};
      expTl   = '{150, 50, 0};
      pulseFsync(32'h1000_0000);
      for (int i = 0; i < 3; i++) begin
         doAddrPhase(i == 2, lens[i], 0, fa, fl, fv, us, ra, aa, rr, rf);
         checks++; if (fa !== expAddr[i] || fl !== 8'(lens[i] - 1) || fv !== 1'b1) begin errors++;
            $display("[TB] FAIL frame ar %0d: got %h/%0d/%b expected %h/%0d/1", i, fa, fl, fv, expAddr[i], lens[i] - 1); end
         checks++; if (ra !== 1'b1 || aa !== 1'b0 || rr !== 1'b1) begin errors++;
            $display("[TB] FAIL frame accept %0d: resp/arvalid/rready got %b%b%b expected 101", i, ra, aa, rr); end
         runReadData(lens[i], 1'b0, -1, 32'h100 * (i + 1), wc, bd, dc, dl, re);
         checks++; if (wc !== lens[i] || bd !== 0) begin errors++;
            $display("[TB] FAIL frame data %0d: writes %0d bad %0d expected %0d/0", i, wc, bd, lens[i]); end
         checks++; if (dc !== 1 || dl !== 1 || re !== 1'b0) begin errors++;
            $display("[TB] FAIL frame done %0d: count %0d latency %0d rready %b expected 1/1/0", i, dc, dl, re); end
         checks++; if (tail_status !== expTs[i] || tail_len !== LS'(expTl[i])) begin errors++;
            $display("[TB] FAIL frame tail %0d: got %b/%0d expected %b/%0d", i, tail_status, tail_len, expTs[i], expTl[i]); end
      end
   endtask

   // arready held low for 20 cycles, then the data arrives with rvalid
   // asserted on every other cycle.
   task automatic test_ar_stall;
      logic [AW-1:0] fa; logic [7:0] fl; logic fv, ra, aa, rr, rf, re;
      int us, wc, bd, dc, dl;
      pulseFsync(32'h2000_0000);
      doAddrPhase(1'b0, 100, 20, fa, fl, fv, us, ra, aa, rr, rf);
      checks++; if (fa !== 32'h2000_0000 || fl !== 8'd99 || fv !== 1'b1) begin errors++;
         $display("[TB] FAIL stall ar: got %h/%0d/%b expected 20000000/99/1", fa, fl, fv); end
      checks++; if (us !== 0) begin errors++;
         $display("[TB] FAIL stall stable: %0d unstable cycles expected 0", us); end
      checks++; if (ra !== 1'b1 || aa !== 1'b0 || rf !== 1'b0) begin errors++;
         $display("[TB] FAIL stall resp: accept %b arvalid %b next %b expected 1/0/0", ra, aa, rf); end
      runReadData(100, 1'b1, -1, 32'h5000, wc, bd, dc, dl, re);
      checks++; if (wc !== 100 || bd !== 0) begin errors++;
         $display("[TB] FAIL toggle data: writes %0d bad %0d expected 100/0", wc, bd); end
      checks++; if (dc !== 1 || dl !== 1) begin errors++;
         $display("[TB] FAIL toggle done: count %0d latency %0d expected 1/1", dc, dl); end
      checks++; if (tail_len !== 9'd150) begin errors++;
         $display("[TB] FAIL toggle tail_len: got %0d expected 150", tail_len); end
   endtask

   // fsync arrives at beat 40 of a 100-beat burst. The burst must finish,
   // and only then may the pointer move to the new base address.
   task automatic test_fsync_mid_burst;
      logic [AW-1:0] fa; logic [7:0] fl; logic fv, ra, aa, rr, rf, re;
      int us, wc, bd, dc, dl;
      doAddrPhase(1'b0, 100, 0, fa, fl, fv, us, ra, aa, rr, rf);
      checks++; if (fa !== 32'h2000_0C80) begin errors++;
         $display("[TB] FAIL midsync ar: got %h expected 20000c80", fa); end
      base_addr = 32'h3000_0000;
      runReadData(100, 1'b0, 40, 32'h9000, wc, bd, dc, dl, re);
      checks++; if (wc !== 100 || bd !== 0 || dc !== 1) begin errors++;
         $display("[TB] FAIL midsync burst: writes %0d bad %0d done %0d expected 100/0/1", wc, bd, dc); end
      checks++; if (tail_status !== 1'b0 || tail_len !== 9'd250) begin errors++;
         $display("[TB] FAIL midsync remain: got %b/%0d expected 0/250", tail_status, tail_len); end
      doAddrPhase(1'b0, 100, 0, fa, fl, fv, us, ra, aa, rr, rf);
      checks++; if (fa !== 32'h3000_0000 || fv !== 1'b1) begin errors++;
         $display("[TB] FAIL midsync new base: got %h/%b expected 30000000/1", fa, fv); end
      runReadData(100, 1'b0, -1, 32'hB000, wc, bd, dc, dl, re);
      checks++; if (wc !== 100 || tail_len !== 9'd150) begin errors++;
         $display("[TB] FAIL midsync follow-up: writes %0d tail_len %0d expected 100/150", wc, tail_len); end
   endtask

   // A zero-length tail request gives resp then done, with no AR traffic.
   task automatic test_zero_len;
      tail_req = 1'b1;
      req_len  = '0;
      @(negedge clock);
      checks++; if ({resp, done, arvalid} !== 3'b100) begin errors++;
         $display("[TB] FAIL zero cycle1: resp/done/arvalid got %b expected 100", {resp, done, arvalid}); end
      tail_req = 1'b0;
      @(negedge clock);
      checks++; if ({resp, done, arvalid} !== 3'b010) begin errors++;
         $display("[TB] FAIL zero cycle2: resp/done/arvalid got %b expected 010", {resp, done, arvalid}); end
      @(negedge clock);
      checks++; if ({resp, done, arvalid} !== 3'b000 || tail_len !== 9'd150) begin errors++;
         $display("[TB] FAIL zero after: ctrl %b tail_len %0d expected 000/150", {resp, done, arvalid}, tail_len); end
   endtask

   // fsync and a request in the same IDLE cycle. The frame restart is
   // taken first and the request one cycle later.
   task automatic test_fsync_vs_request;
      logic re;
      int wc, bd, dc, dl;
      base_addr = 32'h4000_0000;
      fsync     = 1'b1;
      burst_req = 1'b1;
      req_len   = 9'd10;
      @(negedge clock);
      fsync = 1'b0;
      checks++; if (arvalid !== 1'b0) begin errors++;
         $display("[TB] FAIL sync-wins first: arvalid got %b expected 0", arvalid); end
      @(negedge clock);
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h4000_0000 || arlen !== 8'd9) begin errors++;
         $display("[TB] FAIL sync-wins ar: got %b/%h/%0d expected 1/40000000/9", arvalid, araddr, arlen); end
      arready = 1'b1;
      @(negedge clock);
      checks++; if (resp !== 1'b1) begin errors++;
         $display("[TB] FAIL sync-wins resp: got %b expected 1", resp); end
      arready   = 1'b0;
      burst_req = 1'b0;
      runReadData(10, 1'b0, -1, 32'hA000, wc, bd, dc, dl, re);
      checks++; if (wc !== 10 || dc !== 1 || tail_len !== 9'd240 || tail_status !== 1'b0) begin errors++;
         $display("[TB] FAIL sync-wins burst: writes %0d done %0d tail %b/%0d expected 10/1/0/240", wc, dc, tail_status, tail_len); end
   endtask

   // Reset asserted between clock edges in the middle of a data phase. All
   // outputs must clear at once, and the design must restart from IDLE at
   // address 0.
   task automatic test_reset_mid_rdata;
      logic [AW-1:0] fa; logic [7:0] fl; logic fv, ra, aa, rr, rf, re;
      int us, wc, bd, dc, dl;
      doAddrPhase(1'b0, 100, 0, fa, fl, fv, us, ra, aa, rr, rf);
      checks++; if (fa !== 32'h4000_0140) begin errors++;
         $display("[TB] FAIL rstmid ar: got %h expected 40000140", fa); end
      for (int i = 0; i < 5; i++) begin
         rvalid = 1'b1;
         rdata  = {DW/32{32'(i)}};
         @(negedge clock);
      end
      checks++; if (fifo_wr_en !== 1'b1 || rready !== 1'b1) begin errors++;
         $display("[TB] FAIL rstmid active: wr_en %b rready %b expected 1/1", fifo_wr_en, rready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({resp, done, arvalid, rready, fifo_wr_en} !== 5'b0 || fifo_wr_data !== '0) begin errors++;
         $display("[TB] FAIL rstmid async ctrl: got %b expected 00000", {resp, done, arvalid, rready, fifo_wr_en}); end
      checks++; if (araddr !== '0 || arlen !== '0 || {tail_status, tail_len} !== '0) begin errors++;
         $display("[TB] FAIL rstmid async regs: got %h/%h/%b/%0d expected 0", araddr, arlen, tail_status, tail_len); end
      rvalid = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      checks++; if ({rready, arvalid, tail_status} !== 3'b000) begin errors++;
         $display("[TB] FAIL rstmid release: rready/arvalid/tail_status got %b expected 000", {rready, arvalid, tail_status}); end
      doAddrPhase(1'b0, 5, 0, fa, fl, fv, us, ra, aa, rr, rf);
      checks++; if (fa !== 32'h0 || fl !== 8'd4 || fv !== 1'b1) begin errors++;
         $display("[TB] FAIL rstmid restart: got %h/%0d/%b expected 0/4/1", fa, fl, fv); end
      runReadData(5, 1'b0, -1, 32'hC000, wc, bd, dc, dl, re);
      checks++; if (wc !== 5 || bd !== 0 || dc !== 1) begin errors++;
         $display("[TB] FAIL rstmid burst: writes %0d bad %0d done %0d expected 5/0/1", wc, bd, dc); end
   endtask

   initial begin
      rst_n     = 1'b0;
      base_addr = '0;
      fsync     = 1'b0;
      burst_req = 1'b0;
      tail_req  = 1'b0;
      req_len   = '0;
      arready   = 1'b0;
      rdata     = '0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      test_reset;
      test_frame_sequence;
      test_ar_stall;
      test_fsync_mid_burst;
      test_zero_len;
      test_fsync_vs_request;
      test_reset_mid_rdata;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
